uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receiver that consumes the UART line produced by the transmitter stage: 8N1, LSB first, idle-high.
- Recovers bytes with a 2-flop synchronizer and mid-bit sampling.
- Checks the stop bit and presents each byte on a valid/ready handshake to downstream logic on the same 100 MHz board clock.
- Sits between the board UART pin and the loopback/command logic.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per bit (100 MHz / 9600 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycle count from start-edge detection to the start-bit mid-sample.

Ports:
- CLK100MHZ  input  1  system clock, all logic on the rising edge.
- SW0  input  1  reset, asynchronous, active-low.
- UART_TXD_IN  input  1  asynchronous serial line, idle 1.
- rx_data  output  8  received byte, valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts the byte on a clock edge where rx_valid=1 and rx_ready=1.
- rx_busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: new byte completed while the previous one was unaccepted.

Behaviour:
- Reset (SW0=0, async): synchronizer flops=1; FSM=IDLE; counters=0; shift reg=0; rx_data=0x00; rx_valid, rx_busy, frame_err, overrun=0.
- Synchronizer: UART_TXD_IN passes through 2 flops to give rxs (2-cycle latency). All FSM decisions use rxs only.
- IDLE: if rxs=0, go to START with bit counter=0.
- START: count cycles. When count=HALF_BIT-1, sample rxs.
  - rxs=0: go to DATA, counter=0, bit_idx=0.
  - rxs=1: glitch; return to IDLE with no output.
- DATA: when count=CLKS_PER_BIT-1, shift rxs into bit position bit_idx (LSB first) and clear the counter.
  - After bit_idx=7 is sampled, go to STOP.
  - Sample points therefore fall at mid-bit.
- STOP: when count=CLKS_PER_BIT-1, sample rxs.
  - rxs=1: byte complete. Load the output per the handshake rules below, then go to IDLE.
  - rxs=0: pulse frame_err for 1 cycle, discard the byte, go to RECOVER.
- RECOVER: wait for rxs=1, then go to IDLE. A held-low break line never starts a spurious frame.
- Handshake (evaluated at the byte-complete edge):
  - rx_valid=0: load rx_data and set rx_valid=1 on that edge.
  - rx_valid=1 and rx_ready=1 on the same edge: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data, drop the new byte, pulse overrun for 1 cycle.
  - Otherwise rx_valid clears on any edge with rx_valid=1 and rx_ready=1.
  - rx_data holds its last value when rx_valid=0.
- rx_busy: combinational decode of FSM != IDLE, or registered with at most 1 cycle lag.
- Counter widths: wide enough for CLKS_PER_BIT-1 (clog2). bit_idx is 3 bits and does not wrap past 7.
- Reset mid-frame: immediate abort. The partial byte is never delivered and no error pulse is produced.
- A pending rx_valid is also cleared by reset.
- Reception continues while rx_valid=1; only delivery is subject to the overrun rule.

Test Plan (CLKS_PER_BIT=16, bit period 16 cycles):
1. Idle line, send 0x55 with rx_ready=0 -> rx_valid rises about 2+8+8*16+16 cycles after the start edge; rx_data=0x55 held stable; rx_ready pulse -> rx_valid=0 next edge, frame_err=overrun=0 throughout.
2. Drive the line low for 4 cycles, then high -> rx_busy pulses, FSM returns to IDLE, rx_valid stays 0, no error pulses.
3. Send 0xA3 with stop bit 0, hold the line low 50 more cycles, then idle and send 0x3C -> one frame_err pulse; no byte during the low hold; then rx_data=0x3C, rx_valid=1.
4. Back-to-back 0x12 then 0x34, rx_ready=0 -> rx_data=0x12, one overrun pulse at the second stop sample; rx_data still 0x12 afterwards.
5. Repeat 4 with rx_ready asserted exactly on the second byte-complete edge -> rx_data=0x34, rx_valid=1, overrun=0.
6. Assert SW0=0 for 3 cycles during data bit 3 of 0xF0, release, resend 0xF0 -> all outputs 0 during reset, no partial delivery; then rx_data=0xF0, rx_valid=1.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check,
// and a single-entry valid/ready output stage with overrun reporting.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK100MHZ,
  input  logic       SW0,
  input  logic       UART_TXD_IN,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_d;
  logic             valid_d, busy_d, fe_d, ov_d;
  logic             byte_done;
  logic [1:0]       sync_q;
  logic             rxs;

  // Metastability guard; flops reset to the idle-high line level.
  always_ff @(posedge CLK100MHZ or negedge SW0) begin
    if (!SW0) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], UART_TXD_IN};
    end
  end

  assign rxs = sync_q[1];

  always_ff @(posedge CLK100MHZ or negedge SW0) begin
    if (!SW0) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      rx_busy   <= busy_d;
      frame_err <= fe_d;
      overrun   <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = rx_data;
    valid_d   = rx_valid;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    byte_done = 1'b0;

    if (rx_valid && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Half a bit after the falling edge: confirm a real start bit.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shreg_d[idx_q] = rxs;
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low break must return high before another frame can start.
      S_RECOVER: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Delivery: accept into the output slot if empty or being drained now.
    if (byte_done) begin
      if (!rx_valid || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized, self-checking bench for uart_rx_core with a transaction-level
// model of the single-entry output slot.
module tb_uart_rx_core;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned FRAME_CYC = 10 * CPB;
  // 2 sync flops + 1 edge-detect cycle + half bit + 8 data bits + stop bit.
  localparam int unsigned LATENCY = 3 + HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       txd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  int pc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cnt = 0;
  int busy_cyc = 0;
  int rise_pc = 0;
  int fall_pc = 0;
  logic prev_valid = 1'b0;

  logic [7:0] m_data;
  logic       m_valid;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .CLK100MHZ  (clk),
    .SW0        (rst_n),
    .UART_TXD_IN(txd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: counts pulses and valid rises just after each edge.
  always @(posedge clk) begin
    #1;
    pc++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_busy) busy_cyc++;
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_pc = pc;
    end
    prev_valid = rx_valid;
  end

  // Drives one 8N1 frame, one line value per cycle; rx_ready pulses at rdy_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at);
    for (int i = 0; i < int'(FRAME_CYC); i++) begin
      int k;
      k = i / int'(CPB);
      if (k == 0) txd = 1'b0;
      else if (k <= 8) txd = b[k-1];
      else txd = stop;
      if (i == 0) fall_pc = pc;
      rx_ready = (i == rdy_at);
      @(negedge clk);
    end
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    txd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    txd = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b fe=%b ov=%b expected all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int fe0, ov0, r0, lat;
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    send_frame(8'h55, 1'b1, -1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_byte: valid=%b data=%h expected valid=1 data=55", rx_valid, rx_data);
    end
    lat = rise_pc - fall_pc;
    checks++;
    if (rise_cnt != r0 + 1 || lat < int'(LATENCY) - 2 || lat > int'(LATENCY) + 2) begin
      errors++;
      $display("FAIL basic_latency: rises=%0d latency=%0d expected 1 rise at %0d+-2",
               rise_cnt - r0, lat, LATENCY);
    end
    idle(30);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_hold: valid=%b data=%h expected valid=1 data=55", rx_valid, rx_data);
    end
    accept();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: valid=%b expected 0", rx_valid);
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL basic_no_err: fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch();
    int fe0, ov0, r0, b0;
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt; b0 = busy_cyc;
    txd = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    checks++;
    if (busy_cyc == b0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: busy_cycles=%0d busy_now=%b expected >0 and 0",
               busy_cyc - b0, rx_busy);
    end
    checks++;
    if (rx_valid !== 1'b0 || rise_cnt != r0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL glitch_quiet: valid=%b rises=%0d fe=%0d ov=%0d expected all 0",
               rx_valid, rise_cnt - r0, fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_frame_error();
    int fe0, r0;
    fe0 = fe_cnt; r0 = rise_cnt;
    send_frame(8'hA3, 1'b0, -1);
    txd = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 + 1 || rise_cnt != r0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_break: fe=%0d rises=%0d valid=%b expected 1 0 0",
               fe_cnt - fe0, rise_cnt - r0, rx_valid);
    end
    idle(20);
    send_frame(8'h3C, 1'b1, -1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || fe_cnt != fe0 + 1) begin
      errors++;
      $display("FAIL frame_err_resume: valid=%b data=%h fe=%0d expected 1 3c 1",
               rx_valid, rx_data, fe_cnt - fe0);
    end
    accept();
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, -1);
    send_frame(8'h34, 1'b1, -1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h12 || ov_cnt != ov0 + 1) begin
      errors++;
      $display("FAIL overrun_drop: valid=%b data=%h ov=%0d expected 1 12 1",
               rx_valid, rx_data, ov_cnt - ov0);
    end
    idle(10);
    checks++;
    if (rx_data !== 8'h12 || ov_cnt != ov0 + 1) begin
      errors++;
      $display("FAIL overrun_hold: data=%h ov=%0d expected 12 1", rx_data, ov_cnt - ov0);
    end
    accept();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_accept: valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic test_ready_on_complete();
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, -1);
    // Line index 154 is the cycle whose rx_ready is seen on the completion edge.
    send_frame(8'h34, 1'b1, int'(LATENCY) - 1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h34 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL ready_same_edge: valid=%b data=%h ov=%0d expected 1 34 0",
               rx_valid, rx_data, ov_cnt - ov0);
    end
  endtask

  task automatic test_reset_midframe();
    int fe0, ov0, r0;
    logic [7:0] b;
    b = 8'hF0;
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pending: valid=%b expected 1", rx_valid);
    end
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    for (int i = 0; i < int'(FRAME_CYC); i++) begin
      int k;
      k = i / int'(CPB);
      if (i == 68) rst_n = 1'b0;
      if (i == 71) rst_n = 1'b1;
      if (i >= 68) txd = 1'b1;
      else if (k == 0) txd = 1'b0;
      else txd = b[k-1];
      if (i == 69) begin
        checks++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
          errors++;
          $display("FAIL midrst_outputs: data=%h valid=%b busy=%b fe=%b ov=%b expected all 0",
                   rx_data, rx_valid, rx_busy, frame_err, overrun);
        end
      end
      @(negedge clk);
    end
    idle(20);
    checks++;
    if (rise_cnt != r0 || fe_cnt != fe0 || ov_cnt != ov0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_partial: rises=%0d fe=%0d ov=%0d valid=%b expected all 0",
               rise_cnt - r0, fe_cnt - fe0, ov_cnt - ov0, rx_valid);
    end
    send_frame(8'hF0, 1'b1, -1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hF0) begin
      errors++;
      $display("FAIL midrst_resend: valid=%b data=%h expected 1 f0", rx_valid, rx_data);
    end
    accept();
  endtask

  // Random bytes, random stop-bit faults and random consumer behaviour.
  task automatic test_random();
    m_data  = 8'hF0;
    m_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      logic good;
      int fe0, ov0, exp_fe, exp_ov;
      b = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      idle(int'($urandom_range(4, 12)));
      fe0 = fe_cnt; ov0 = ov_cnt;
      exp_fe = good ? 0 : 1;
      exp_ov = (good && m_valid) ? 1 : 0;
      send_frame(b, good, -1);
      txd = 1'b1;
      if (good && !m_valid) begin
        m_data  = b;
        m_valid = 1'b1;
      end
      checks++;
      if (rx_valid !== m_valid || rx_data !== m_data ||
          fe_cnt - fe0 != exp_fe || ov_cnt - ov0 != exp_ov) begin
        errors++;
        $display("FAIL random_%0d: valid=%b data=%h fe=%0d ov=%0d expected %b %h %0d %0d",
                 n, rx_valid, rx_data, fe_cnt - fe0, ov_cnt - ov0,
                 m_valid, m_data, exp_fe, exp_ov);
      end
      if (m_valid && $urandom_range(0, 1) == 1) begin
        accept();
        m_valid = 1'b0;
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== m_data) begin
          errors++;
          $display("FAIL random_accept_%0d: valid=%b data=%h expected 0 %h",
                   n, rx_valid, rx_data, m_data);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    txd = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_ready_on_complete();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
